// File: rtl/shift_pkg.sv
// Shared encodings and the fill-bit helper for the burst shift register.
// Optional feature macro: SHIFT_ROTATE_EN (enables the rotate fill path).
package shift_pkg;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

`ifdef SHIFT_ROTATE_EN
    // Bit entering the register for one step; 'leaving' is the bit pushed out.
    function automatic logic fill_bit(input logic [1:0] mode, input logic dir,
                                      input logic in_bit, input logic msb,
                                      input logic leaving);
        logic f;
        f = in_bit;
        case (mode)
            MODE_LOGIC: f = in_bit;
            MODE_ROT:   f = leaving;
            MODE_ARITH: f = (dir == DIR_RIGHT) ? msb : in_bit;
            default:    f = in_bit;
        endcase
        return f;
    endfunction
`else
    // Bit entering the register for one step; rotate decodes as logical.
    function automatic logic fill_bit(input logic [1:0] mode, input logic dir,
                                      input logic in_bit, input logic msb);
        logic f;
        f = in_bit;
        case (mode)
            MODE_LOGIC: f = in_bit;
            MODE_ROT:   f = in_bit;
            MODE_ARITH: f = (dir == DIR_RIGHT) ? msb : in_bit;
            default:    f = in_bit;
        endcase
        return f;
    endfunction
`endif

endpackage

// File: rtl/shift_burst_ctrl.sv
// IDLE/RUN burst controller: remaining counter, busy/done, step enable and
// the dir/mode the data path should use this cycle.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int CNT_W = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_shift,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_step,
    output logic             o_dir,
    output logic [1:0]       o_mode,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_busy;
    logic             r_done;

    logic             w_state_n;
    logic [CNT_W-1:0] w_rem_n;
    logic             w_dir_n;
    logic [1:0]       w_mode_n;
    logic             w_busy_n;
    logic             w_done_n;

    // Next-state decode; load overrides everything and aborts a running burst.
    always_comb begin
        w_state_n = r_state;
        w_rem_n   = r_remaining;
        w_dir_n   = r_dir;
        w_mode_n  = r_mode;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        if (i_load) begin
            w_state_n = S_IDLE;
            w_rem_n   = CNT_ZERO;
            w_busy_n  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_count != CNT_ZERO) begin
                            w_state_n = S_RUN;
                            w_rem_n   = i_count;
                            w_dir_n   = i_dir;
                            w_mode_n  = i_mode;
                            w_busy_n  = 1'b1;
                        end else begin
                            w_done_n = 1'b1;
                        end
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                S_RUN: begin
                    w_rem_n = r_remaining - CNT_ONE;
                    if (r_remaining == CNT_ONE) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_RUN;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end
            endcase
        end
    end

    // Step enable: every RUN edge steps; in IDLE a lone shift strobe steps.
    always_comb begin
        o_step = 1'b0;
        if (i_load) begin
            o_step = 1'b0;
        end else if (r_state == S_RUN) begin
            o_step = 1'b1;
        end else if (i_start) begin
            o_step = 1'b0;
        end else begin
            o_step = i_shift;
        end
    end

    // A burst uses the latched dir/mode; single steps use the live inputs.
    always_comb begin
        if (r_state == S_RUN) begin
            o_dir  = r_dir;
            o_mode = r_mode;
        end else begin
            o_dir  = i_dir;
            o_mode = i_mode;
        end
    end

    // Controller state registers with async and soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= CNT_ZERO;
            r_dir       <= DIR_LEFT;
            r_mode      <= MODE_LOGIC;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_srst) begin
            r_state     <= S_IDLE;
            r_remaining <= CNT_ZERO;
            r_dir       <= DIR_LEFT;
            r_mode      <= MODE_LOGIC;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_remaining <= w_rem_n;
            r_dir       <= w_dir_n;
            r_mode      <= w_mode_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/shift_reg_burst.sv
// Parametrised bidirectional shift register with parallel load, single step
// and counted burst shifting. Optional macro SHIFT_ROTATE_EN enables rotate
// mode; without it mode 01 behaves as a logical shift.
module shift_reg_burst
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(WIDTH + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_in_bit,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic [WIDTH-1:0] o_out,
    output logic             o_out_bit,
    output logic             o_busy,
    output logic             o_done
);

    logic             r_out;
    logic [WIDTH-1:0] r_data;
    logic             w_step;
    logic             w_dir;
    logic [1:0]       w_mode;
    logic             w_fill;
    logic [WIDTH-1:0] w_next_data;
    logic             w_next_bit;

    shift_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_srst  (i_srst),
        .i_load  (i_load),
        .i_start (i_start),
        .i_shift (i_shift),
        .i_dir   (i_dir),
        .i_mode  (i_mode),
        .i_count (i_count),
        .o_step  (w_step),
        .o_dir   (w_dir),
        .o_mode  (w_mode),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

`ifdef SHIFT_ROTATE_EN
    logic w_leaving;
    assign w_leaving = (w_dir == DIR_LEFT) ? r_data[WIDTH-1] : r_data[0];
    assign w_fill    = fill_bit(w_mode, w_dir, i_in_bit, r_data[WIDTH-1], w_leaving);
`else
    assign w_fill    = fill_bit(w_mode, w_dir, i_in_bit, r_data[WIDTH-1]);
`endif

    // One-step result in the selected direction.
    always_comb begin
        w_next_data = r_data;
        w_next_bit  = r_out;
        if (w_dir == DIR_LEFT) begin
            w_next_data = {r_data[WIDTH-2:0], w_fill};
            w_next_bit  = r_data[WIDTH-1];
        end else begin
            w_next_data = {w_fill, r_data[WIDTH-1:1]};
            w_next_bit  = r_data[0];
        end
    end

    // Data register and serial out bit; load wins, hold mode freezes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= RESET_VAL;
            r_out  <= 1'b0;
        end else if (i_srst) begin
            r_data <= RESET_VAL;
            r_out  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_in;
        end else if (w_step && (w_mode != MODE_HOLD)) begin
            r_data <= w_next_data;
            r_out  <= w_next_bit;
        end else begin
            r_data <= r_data;
            r_out  <= r_out;
        end
    end

    assign o_out     = r_data;
    assign o_out_bit = r_out;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed bench for shift_reg_burst (WIDTH = 8): a table of single-cycle
// vectors followed by hand-written burst sequences.
module tb_shift_reg_burst;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       srst;
    logic [7:0] din;
    logic       in_bit;
    logic       load;
    logic       shift;
    logic       dir;
    logic [1:0] mode;
    logic       start;
    logic [3:0] count;
    logic [7:0] dout;
    logic       out_bit;
    logic       busy;
    logic       done;

    int total;
    int bad;

    typedef struct {
        logic       load;
        logic       shift;
        logic       dir;
        logic [1:0] mode;
        logic       in_bit;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic       exp_bit;
    } vec_t;

    vec_t vecs[12];

    shift_reg_burst #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_srst    (srst),
        .i_in      (din),
        .i_in_bit  (in_bit),
        .i_load    (load),
        .i_shift   (shift),
        .i_dir     (dir),
        .i_mode    (mode),
        .i_start   (start),
        .i_count   (count),
        .o_out     (dout),
        .o_out_bit (out_bit),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int done_at;
        int nbusy;
        int npulse;

        total = 0;
        bad   = 0;
        srst = 1'b0; din = 8'h00; in_bit = 1'b0; load = 1'b0; shift = 1'b0;
        dir = 1'b0; mode = 2'b00; start = 1'b0; count = 4'd0;

        // load shift dir mode in_bit din exp_out exp_bit
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'hA5, 8'hA5, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 8'h4B, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 8'h25, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h00, 8'h92, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 8'hC9, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 8'h92, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 8'h00, 8'h92, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 8'h3C, 8'h3C, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h00, 8'h3C, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00,
                     ROT_EN ? 8'h78 : 8'h79, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 8'h3C,
                     ROT_EN ? 1'b0 : 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00,
                     ROT_EN ? 8'h1E : 8'h9E, 1'b0};

        // Asynchronous reset with no clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out", {24'd0, dout}, 32'h00);
        chk("reset_bit", {31'd0, out_bit}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        #3 rst_n = 1'b1;

        // Table of single-cycle operations
        for (int i = 0; i < 12; i++) begin
            load = vecs[i].load; shift = vecs[i].shift; dir = vecs[i].dir;
            mode = vecs[i].mode; in_bit = vecs[i].in_bit; din = vecs[i].din;
            tick();
            load = 1'b0; shift = 1'b0;
            chk($sformatf("vec%0d_out", i), {24'd0, dout}, {24'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d_bit", i), {31'd0, out_bit}, {31'd0, vecs[i].exp_bit});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'h0);
            chk($sformatf("vec%0d_done", i), {31'd0, done}, 32'h0);
        end

        // Burst rotate left by 3 from 0x81
        din = 8'h81; load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; count = 4'd3; dir = 1'b0; mode = 2'b01; in_bit = 1'b0;
        tick();
        start = 1'b0; dir = 1'b1; mode = 2'b10;
        chk("rot_start_out", {24'd0, dout}, 32'h81);
        nbusy = busy ? 1 : 0;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) nbusy++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        chk("rot_done_edge", done_at, 32'd3);
        chk("rot_busy_cycles", nbusy, 32'd3);
        chk("rot_out", {24'd0, dout}, ROT_EN ? 32'h0C : 32'h08);
        tick();
        chk("rot_done_single", {31'd0, done}, 32'h0);

        // Shift strobe and changed live dir/mode are ignored during a burst
        din = 8'h0C; load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; count = 4'd2; dir = 1'b0; mode = 2'b00; in_bit = 1'b1;
        tick();
        start = 1'b0; shift = 1'b1; dir = 1'b1; mode = 2'b10;
        chk("ign_busy", {31'd0, busy}, 32'h1);
        tick();
        chk("ign_mid", {24'd0, dout}, 32'h19);
        tick();
        shift = 1'b0;
        chk("ign_out", {24'd0, dout}, 32'h33);
        chk("ign_done", {31'd0, done}, 32'h1);

        // Zero-count start
        din = 8'h5A; load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; count = 4'd0; tick(); start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'h1);
        chk("zero_busy", {31'd0, busy}, 32'h0);
        chk("zero_out", {24'd0, dout}, 32'h5A);
        tick();
        chk("zero_done_clear", {31'd0, done}, 32'h0);

        // Load at burst cycle 2 aborts without done
        din = 8'h33; load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; count = 4'd5; dir = 1'b0; mode = 2'b00; in_bit = 1'b0;
        tick(); start = 1'b0;
        tick();
        chk("abort_mid", {24'd0, dout}, 32'h66);
        din = 8'h3C; load = 1'b1; tick(); load = 1'b0;
        chk("abort_out", {24'd0, dout}, 32'h3C);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) npulse++;
        end
        chk("abort_no_done", npulse, 32'd0);
        chk("abort_hold", {24'd0, dout}, 32'h3C);

        // Back-to-back bursts: second start in the done cycle
        start = 1'b1; count = 4'd2; dir = 1'b0; mode = 2'b00; in_bit = 1'b0;
        tick(); start = 1'b0;
        tick();
        tick();
        chk("b2b_first_done", {31'd0, done}, 32'h1);
        chk("b2b_first_out", {24'd0, dout}, 32'hF0);
        start = 1'b1; count = 4'd8; dir = 1'b1; mode = 2'b00; in_bit = 1'b0;
        tick(); start = 1'b0;
        chk("b2b_second_busy", {31'd0, busy}, 32'h1);
        chk("b2b_done_clear", {31'd0, done}, 32'h0);
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                done_at = k;
                break;
            end
        end
        chk("b2b_done_edge", done_at, 32'd8);
        chk("b2b_out", {24'd0, dout}, 32'h00);
        chk("b2b_bit", {31'd0, out_bit}, 32'h1);

        // Reset mid-burst takes effect without a clock edge
        din = 8'h55; load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; count = 4'd5; dir = 1'b0; mode = 2'b00; in_bit = 1'b1;
        tick(); start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {24'd0, dout}, 32'h00);
        chk("rst_mid_busy", {31'd0, busy}, 32'h0);
        chk("rst_mid_done", {31'd0, done}, 32'h0);
        chk("rst_mid_bit", {31'd0, out_bit}, 32'h0);
        #1 rst_n = 1'b1;
        npulse = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (done) npulse++;
        end
        chk("rst_mid_no_done", npulse, 32'd0);
        chk("rst_mid_out_after", {24'd0, dout}, 32'h00);

        // Synchronous soft reset
        din = 8'hAA; load = 1'b1; tick(); load = 1'b0;
        srst = 1'b1; tick(); srst = 1'b0;
        chk("srst_out", {24'd0, dout}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_burst.md
# shift_reg_burst

Parametrised bidirectional shift register with parallel load, single-step shift, and a counted burst-shift engine with busy/done handshake. It generalises the fixed 8-bit left shifter to any width. It adds right shifts, arithmetic and rotate modes, and a serial output bit. It sits in the sequential-logic layer as the building block for serialisers, deserialisers and the ALU's multi-bit shift path.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- RESET_VAL, 0, value of `out` after reset, WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the burst count input; derived, not overridden.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  WIDTH  parallel load value.
- in_bit  in  1  serial fill bit, used by logical shifts.
- load  in  1  parallel load strobe.
- shift  in  1  single-step shift strobe.
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB).
- mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 hold.
- start  in  1  begins a burst of `count` shifts.
- count  in  CNT_W  number of shifts in a burst.
- out  out  WIDTH  register contents.
- out_bit  out  1  last bit shifted out.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Reset values: out = RESET_VAL, out_bit = 0, busy = 0, done = 0, FSM = IDLE.
- One step, left: out ← {out[W-2:0], fill}, out_bit ← out[W-1].
- One step, right: out ← {fill, out[W-1:1]}, out_bit ← out[0].
- Fill by mode:
  - logical: in_bit.
  - rotate: the bit leaving the register.
  - arithmetic: out[W-1] when shifting right; in_bit when shifting left.
  - hold: no change to out or out_bit.
- Priority per edge: load > start > shift.
- load: out ← in; out_bit unchanged. In RUN, load aborts the burst: busy ← 0 and no done pulse.
- FSM IDLE:
  - start with count ≠ 0: latch dir, mode and count into the remaining counter; go to RUN; busy ← 1. No shift happens on the start edge.
  - start with count = 0: done ← 1 next cycle; stay in IDLE; busy never asserts.
  - shift: perform one step using the live dir and mode.
- FSM RUN:
  - Each edge performs one step with the latched dir and mode; in_bit is sampled live every edge.
  - Each edge decrements remaining. When remaining goes 1→0: go to IDLE, busy ← 0, done ← 1 for exactly one cycle.
  - shift and start are ignored while busy.
- count may exceed WIDTH; shifting simply continues, and rotate wraps modulo WIDTH.
- Reset asserted mid-burst: all state returns to reset values immediately; no done pulse.

## Timing
- load and single shift: result visible on `out` one edge after the strobe is sampled.
- Burst:
  - start sampled at edge 0; shifts occur at edges 1..count.
  - busy is high after edge 0 through edge count−1.
  - done is high for the single cycle after edge count.
  - Total latency from start to done is count+1 edges.
- start may be asserted in the cycle where done is high; that burst begins on that edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SHIFT_ROTATE_EN defined: mode 01 rotates as specified above.
- SHIFT_ROTATE_EN undefined:
  - mode 01 decodes as logical (fill = in_bit); no rotate mux is synthesised.
  - All other modes are unchanged.

## Structure
- Package `shift_pkg` holds:
  - mode encodings MODE_LOGIC, MODE_ROT, MODE_ARITH, MODE_HOLD;
  - DIR_LEFT and DIR_RIGHT;
  - FSM state encodings S_IDLE and S_RUN.
- Sub-module `shift_burst_ctrl` holds the IDLE/RUN FSM, the remaining counter and the busy/done outputs. It emits a step-enable plus the latched dir and mode.
- The top level holds the data register, the fill multiplexer and out_bit.

## Test plan
All scenarios use WIDTH = 8.
- Reset: hold rst_n = 0 mid-burst → out = 0x00, busy = 0, done = 0, with no clock edge needed.
- Parallel load and step:
  - load 0xA5, then shift, dir = 0, logical, in_bit = 1 → out = 0x4B, out_bit = 1.
  - shift again, dir = 1, arithmetic → out = 0x25, out_bit = 1.
- Burst rotate: load 0x81, then start with count = 3, dir = 0, rotate → busy for 3 cycles, then out = 0x0C and done is high one cycle exactly 4 edges after start. Without SHIFT_ROTATE_EN, the same stimulus with in_bit = 0 → out = 0x08.
- Zero count: start with count = 0 → done pulses once next cycle, busy stays 0, out is unchanged.
- Priorities:
  - shift asserted during a burst → ignored, and the burst result still matches the count.
  - load 0x3C at burst cycle 2 → out = 0x3C, busy = 0, and no done pulse.
- Back-to-back: start asserted in the done cycle with count = 8, right, logical, in_bit = 0 → out = 0x00 after 8 shifts and a second done pulse.
